// File: rtl/vector_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vector_pkg : shared types for the enemy draw arbiter                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package vector_pkg;

    localparam int N_ENEMY      = 3;
    localparam int COORD_W      = 8;
    localparam int SPRITE_ADR_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PICK  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } arb_state_t;

    typedef struct packed {
        logic [COORD_W-1:0]      x;
        logic [COORD_W-1:0]      y;
        logic [SPRITE_ADR_W-1:0] adr;
    } draw_job_t;

    function automatic logic [N_ENEMY-1:0] idx_onehot(input logic [1:0] idx);
        return N_ENEMY'(1) << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_priority_pick : first pending slot scanning ptr, ptr+1, ptr+2     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_priority_pick
    import vector_pkg::*;
(
    input  logic [N_ENEMY-1:0] i_pending,
    input  logic [1:0]         i_ptr,
    output logic [1:0]         o_sel,
    output logic               o_valid
);

    logic [2:0] w_sum;
    logic [1:0] w_idx;

    // Scan from the far end so the slot closest to ptr wins last.
    always_comb begin
        o_sel   = 2'd0;
        o_valid = 1'b0;
        w_sum   = 3'd0;
        w_idx   = 2'd0;
        for (int k = N_ENEMY - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + 3'(k);
            w_idx = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
            if (i_pending[w_idx]) begin
                o_sel   = w_idx;
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/enemy_draw_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | enemy_draw_arbiter : per-frame round-robin sharing of the draw engine|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module enemy_draw_arbiter
    import vector_pkg::*;
#(
    parameter int OUT_WIDTH      = COORD_W,
    parameter int ADDRESSWIDTH   = SPRITE_ADR_W,
    parameter int TIMEOUT_CYCLES = 4096
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_frame_start,
    input  logic [N_ENEMY-1:0]      i_spawn_enemy,
    input  logic [OUT_WIDTH-1:0]    i_xenemy    [N_ENEMY],
    input  logic [OUT_WIDTH-1:0]    i_yenemy    [N_ENEMY],
    input  logic [ADDRESSWIDTH-1:0] i_adr_enemy [N_ENEMY],
    output logic                    o_draw_start,
    output logic [OUT_WIDTH-1:0]    o_draw_x,
    output logic [OUT_WIDTH-1:0]    o_draw_y,
    output logic [ADDRESSWIDTH-1:0] o_draw_adr,
    input  logic                    i_draw_done,
    output logic [N_ENEMY-1:0]      o_grant,
    output logic                    o_busy,
    output logic                    o_frame_done,
    output logic                    o_timeout,
    output logic                    o_overrun
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t          r_state;
    logic [1:0]          r_ptr;
    logic [1:0]          r_sel;
    logic [N_ENEMY-1:0]  r_pending;
    logic [CNT_W-1:0]    r_cnt;
    draw_job_t           r_jobs [N_ENEMY];

    logic [1:0]          w_sel;
    logic                w_valid;
    logic [N_ENEMY-1:0]  w_left;
    draw_job_t           w_job;

    rr_priority_pick u_pick (
        .i_pending (r_pending),
        .i_ptr     (r_ptr),
        .o_sel     (w_sel),
        .o_valid   (w_valid)
    );

    assign w_left = r_pending & ~idx_onehot(r_sel);
    assign w_job  = r_jobs[w_sel];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= 2'd0;
            r_sel        <= 2'd0;
            r_pending    <= '0;
            r_cnt        <= '0;
            for (int i = 0; i < N_ENEMY; i++) begin
                r_jobs[i] <= '0;
            end
            o_draw_start <= 1'b0;
            o_draw_x     <= '0;
            o_draw_y     <= '0;
            o_draw_adr   <= '0;
            o_grant      <= '0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_timeout    <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_draw_start <= 1'b0;
            o_frame_done <= 1'b0;
            o_timeout    <= 1'b0;
            o_overrun    <= i_frame_start && (r_state != ST_IDLE);

            case (r_state)
                ST_IDLE: begin
                    if (i_frame_start) begin
                        for (int i = 0; i < N_ENEMY; i++) begin
                            r_jobs[i] <= '{x:   COORD_W'(i_xenemy[i]),
                                           y:   COORD_W'(i_yenemy[i]),
                                           adr: SPRITE_ADR_W'(i_adr_enemy[i])};
                        end
                        r_pending <= i_spawn_enemy;
                        o_busy    <= 1'b1;
                        if (|i_spawn_enemy) begin
                            r_state <= ST_PICK;
                        end else begin
                            r_state      <= ST_DONE;
                            o_frame_done <= 1'b1;
                        end
                    end
                end

                ST_PICK: begin
                    if (w_valid) begin
                        r_sel        <= w_sel;
                        o_draw_start <= 1'b1;
                        o_draw_x     <= OUT_WIDTH'(w_job.x);
                        o_draw_y     <= OUT_WIDTH'(w_job.y);
                        o_draw_adr   <= ADDRESSWIDTH'(w_job.adr);
                        o_grant      <= idx_onehot(w_sel);
                        r_state      <= ST_ISSUE;
                    end else begin
                        r_state      <= ST_DONE;
                        o_frame_done <= 1'b1;
                    end
                end

                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    // A completion in the last watchdog cycle wins over the timeout.
                    if (i_draw_done || (r_cnt == CNT_LAST)) begin
                        o_timeout <= ~i_draw_done;
                        r_pending <= w_left;
                        if (|w_left) begin
                            r_state <= ST_PICK;
                        end else begin
                            r_state      <= ST_DONE;
                            o_frame_done <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    r_ptr   <= (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
                    o_grant <= '0;
                    o_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    o_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
